// File: rtl/loteria_pkg.sv
// Shared constants for the lottery game: digit limits, key indices and the
// 7-segment map used by both the input conditioner and the display logic.
package loteria_pkg;

    localparam logic [2:0] NUM_DIGITS = 3'd5;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    localparam int NUM_KEYS   = 3;
    localparam int KEY_INSERT = 0;
    localparam int KEY_FINISH = 1;
    localparam int KEY_CLEAR  = 2;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; non-digits are blanked.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [2:0] count_inc(input logic [2:0] c);
        return (c >= NUM_DIGITS) ? NUM_DIGITS : c + 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer plus counter debouncer. Emits a
// single-cycle press event (combinational) when a new pressed level is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable_n;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= 1'b1;
            sync_b   <= 1'b1;
            stable_n <= 1'b1;
            cnt      <= '0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            if (sync_b == stable_n) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable_n <= sync_b;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Left combinational so the top can register its strobe on the accept edge.
    assign press = (sync_b != stable_n) && (cnt == LAST) && !sync_b;

endmodule

// File: rtl/loteria_input_cond.sv
// Lottery front end: debounces the three keys, synchronizes the digit switches
// and enforces the five-digits / finish / clear entry protocol.
module loteria_input_cond
    import loteria_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] key_n,
    input  logic [3:0] sw,
    output logic [3:0] num,
    output logic       insert,
    output logic       finish,
    output logic       clear,
    output logic       digit_err,
    output logic [2:0] count,
    output logic       done
);

    logic [NUM_KEYS-1:0] ev;
    logic [3:0]          sw_a;
    logic [3:0]          sw_sync;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .key_n(key_n[k]),
            .press(ev[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_a    <= '0;
            sw_sync <= '0;
        end else begin
            sw_a    <= sw;
            sw_sync <= sw_a;
        end
    end

    // Clear has priority; insert and finish are mutually exclusive through count.
    always_ff @(posedge clk) begin
        if (reset) begin
            num       <= '0;
            insert    <= 1'b0;
            finish    <= 1'b0;
            clear     <= 1'b0;
            digit_err <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            insert <= 1'b0;
            finish <= 1'b0;
            clear  <= 1'b0;
            if (ev[KEY_CLEAR]) begin
                clear     <= 1'b1;
                num       <= '0;
                count     <= '0;
                digit_err <= 1'b0;
                done      <= 1'b0;
            end else begin
                if (ev[KEY_INSERT] && !done && count != NUM_DIGITS) begin
                    if (sw_sync > DIGIT_MAX) begin
                        digit_err <= 1'b1;
                    end else begin
                        num       <= sw_sync;
                        insert    <= 1'b1;
                        count     <= count_inc(count);
                        digit_err <= 1'b0;
                    end
                end
                if (ev[KEY_FINISH] && !done && count == NUM_DIGITS) begin
                    finish <= 1'b1;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_loteria_input_cond.sv
// Directed bench for loteria_input_cond with a short debounce window.
module tb_loteria_input_cond;

    localparam int KI = 0;
    localparam int KF = 1;
    localparam int KC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] key_n;
    logic [3:0] sw;
    logic [3:0] num;
    logic       insert, finish, clear, digit_err, done;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    int ins_cnt = 0;
    int fin_cnt = 0;
    int clr_cnt = 0;

    typedef struct {
        int key; int sw;
        int num; int cnt; int err; int done;
        int dins; int dfin; int dclr;
    } vec_t;

    vec_t vt[20];

    loteria_input_cond #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .sw       (sw),
        .num      (num),
        .insert   (insert),
        .finish   (finish),
        .clear    (clear),
        .digit_err(digit_err),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ins_cnt <= ins_cnt + int'(insert);
        fin_cnt <= fin_cnt + int'(finish);
        clr_cnt <= clr_cnt + int'(clear);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        key_n[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key_n[k] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input int n, input int c, input int e, input int d);
        chk({tag, " num"}, int'(num), n);
        chk({tag, " count"}, int'(count), c);
        chk({tag, " digit_err"}, int'(digit_err), e);
        chk({tag, " done"}, int'(done), d);
    endtask

    initial begin
        int bi, bf, bc;

        vt[0]  = '{KI, 12, 5, 1, 1, 0, 0, 0, 0};
        vt[1]  = '{KI,  0, 0, 2, 0, 0, 1, 0, 0};
        vt[2]  = '{KF,  0, 0, 2, 0, 0, 0, 0, 0};
        vt[3]  = '{KC,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[4]  = '{KI,  5, 5, 1, 0, 0, 1, 0, 0};
        vt[5]  = '{KI,  0, 0, 2, 0, 0, 1, 0, 0};
        vt[6]  = '{KI,  9, 9, 3, 0, 0, 1, 0, 0};
        vt[7]  = '{KF,  9, 9, 3, 0, 0, 0, 0, 0};
        vt[8]  = '{KI,  6, 6, 4, 0, 0, 1, 0, 0};
        vt[9]  = '{KI,  7, 7, 5, 0, 0, 1, 0, 0};
        vt[10] = '{KI,  3, 7, 5, 0, 0, 0, 0, 0};
        vt[11] = '{KI, 15, 7, 5, 0, 0, 0, 0, 0};
        vt[12] = '{KF,  0, 7, 5, 0, 1, 0, 1, 0};
        vt[13] = '{KI,  2, 7, 5, 0, 1, 0, 0, 0};
        vt[14] = '{KF,  2, 7, 5, 0, 1, 0, 0, 0};
        vt[15] = '{KC,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[16] = '{KI,  4, 4, 1, 0, 0, 1, 0, 0};
        vt[17] = '{KC,  4, 0, 0, 0, 0, 0, 0, 1};
        vt[18] = '{KI, 10, 0, 0, 1, 0, 0, 0, 0};
        vt[19] = '{KC, 10, 0, 0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        key_n = 3'b111;
        sw    = 4'd5;
        repeat (3) @(negedge clk);
        chk_state("reset", 0, 0, 0, 0);
        chk("reset strobes", int'({insert, finish, clear}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Exact latency: strobe only after edge 5, then held key gives no more.
        bi = ins_cnt;
        key_n[KI] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency insert edge%0d", e), int'(insert), (e == 5) ? 1 : 0);
            if (e == 5) begin
                chk("latency num", int'(num), 5);
                chk("latency count", int'(count), 1);
            end
        end
        repeat (50) @(negedge clk);
        key_n[KI] = 1'b1;
        repeat (12) @(negedge clk);
        chk("long hold single strobe", ins_cnt - bi, 1);

        // Glitch of 3 cycles.
        bi = ins_cnt;
        key_n[KI] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[KI] = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch no insert", ins_cnt - bi, 0);
        chk("glitch count", int'(count), 1);

        for (int i = 0; i < 20; i++) begin
            sw = 4'(vt[i].sw);
            bi = ins_cnt; bf = fin_cnt; bc = clr_cnt;
            press(vt[i].key, 10);
            chk_state($sformatf("vec%0d", i), vt[i].num, vt[i].cnt, vt[i].err, vt[i].done);
            chk($sformatf("vec%0d insert pulses", i), ins_cnt - bi, vt[i].dins);
            chk($sformatf("vec%0d finish pulses", i), fin_cnt - bf, vt[i].dfin);
            chk($sformatf("vec%0d clear pulses", i), clr_cnt - bc, vt[i].dclr);
        end

        // Clear and insert on the same edge.
        sw = 4'd8;
        press(KI, 10);
        chk_state("pre-simul", 8, 1, 0, 0);
        bi = ins_cnt; bc = clr_cnt;
        @(negedge clk);
        key_n[KI] = 1'b0;
        key_n[KC] = 1'b0;
        repeat (10) @(negedge clk);
        key_n = 3'b111;
        repeat (12) @(negedge clk);
        chk("simul clear pulses", clr_cnt - bc, 1);
        chk("simul insert pulses", ins_cnt - bi, 0);
        chk_state("simul", 0, 0, 0, 0);

        // Reset interrupting a debounce in progress.
        sw = 4'd3;
        press(KI, 10);
        chk_state("pre-reset", 3, 1, 0, 0);
        bi = ins_cnt;
        @(negedge clk);
        key_n[KI] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        key_n[KI] = 1'b1;
        repeat (2) @(negedge clk);
        chk_state("mid reset", 0, 0, 0, 0);
        chk("mid reset strobes", int'({insert, finish, clear}), 0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("interrupted press no insert", ins_cnt - bi, 0);
        chk("interrupted press count", int'(count), 0);

        // Key held through reset fires exactly once afterwards.
        bi = ins_cnt;
        @(negedge clk);
        key_n[KI] = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        key_n[KI] = 1'b1;
        repeat (12) @(negedge clk);
        chk("held through reset pulses", ins_cnt - bi, 1);
        chk_state("held through reset", 3, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loteria_input_cond.md
# loteria_input_cond

Front-end conditioner for the lottery game: turns raw DE2 push-buttons and digit switches into the clean, single-cycle `insert`/`finish` strobes and the stable 4-bit `num` that the lottery FSM consumes. It sits between the board pins and the FSM, and it enforces the entry protocol before the FSM sees anything:
- exactly five valid digits (0–9);
- then one finish;
- then a clear.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key change (10 ms at 50 MHz); minimum 2.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W ≥ `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: reset, synchronous, active-high.
- `key_n`  in  3: raw buttons, active-low, asynchronous. [0]=insert, [1]=finish, [2]=clear.
- `sw`  in  4: raw digit switches, asynchronous.
- `num`  out  4: last accepted digit; held between accepts.
- `insert`  out  1: one-cycle strobe; a digit has been accepted.
- `finish`  out  1: one-cycle strobe; the round has been closed.
- `clear`  out  1: one-cycle strobe; the top level ORs it into the FSM reset.
- `digit_err`  out  1: the last insert press carried an invalid digit (>9).
- `count`  out  3: number of accepted digits, 0–5.
- `done`  out  1: the round has been closed; all inputs are locked until clear.

## Operation
- Each key passes through a 2-flop synchronizer, then a per-key debouncer.
  - The debouncer holds a `stable` level, reset to released, and a counter.
  - Counter behaviour: cleared whenever synced == `stable`; incremented otherwise.
  - When synced ≠ `stable` and the counter == `DEBOUNCE_CYCLES`-1: `stable` takes the synced value, the counter clears, and a press event fires if the new level is pressed.
  - Release never generates an event.
- `sw` is 2-flop synchronized. It is sampled only on an insert press event.
- Insert event, evaluated in priority order:
  - If `done` or `count`==5: ignored. No strobe, no change.
  - Else if `sw_sync` > 9: `digit_err`←1. `num` and `count` unchanged, no strobe.
  - Else: `num`←`sw_sync`, `insert` pulses, `count`+1, `digit_err`←0.
- Finish event:
  - Accepted only if `count`==5 and !`done`.
  - When accepted: `finish` pulses and `done`←1.
  - Otherwise ignored.
- Clear event:
  - `clear` pulses.
  - `num`, `count`, `digit_err` and `done` all go to 0.
  - Debouncer state is kept, so a held key is not re-fired.
- Simultaneous events in one cycle:
  - Clear wins; insert and finish are dropped.
  - Insert and finish cannot both be accepted, because their `count` conditions are exclusive.
- `reset` returns everything to its reset value, including the synchronizers, debouncers and counters. A key held through reset is debounced afresh and fires once after release of `reset`.
- Unsigned arithmetic. `count` never exceeds 5; it saturates by the rule above.

## Timing
- Reset values: `num`=0, `insert`=0, `finish`=0, `clear`=0, `digit_err`=0, `count`=0, `done`=0.
- Latency: let edge 0 be the first edge at which the raw key is sampled pressed.
  - The strobe is high for exactly one cycle after edge `DEBOUNCE_CYCLES`+1.
  - `num` and `count` update on the same edge as the strobe.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no event.
- Each press yields at most one strobe, however long the key is held.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `loteria_pkg` holds:
  - `NUM_DIGITS`=5 and `DIGIT_MAX`=9;
  - key index constants `KEY_INSERT`, `KEY_FINISH`, `KEY_CLEAR`;
  - the 7-segment map, shared with the display logic.
- One sub-module, `key_debounce`: synchronizer, counter and press-event output. It is instantiated three times.
- Top-level control (acceptance rules, `count`, `done`) stays flat in `loteria_input_cond`.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- Hold `key_n[0]` low with `sw`=5. Expect `insert` high for one cycle after edge 5, `num`=5, `count`=1. Hold the key for 50 cycles: no second strobe.
- Bounce `key_n[0]` low for 3 cycles, then high. Expect no `insert` and `count` unchanged.
- Press insert with `sw`=12. Expect `digit_err`=1, `num` and `count` unchanged. Then press with `sw`=0: `digit_err`=0, `count`+1.
- Run the full round: inserts of 5,0,9,6,7 give `count`=5. A 6th insert is ignored. Finish then gives one `finish` strobe and `done`=1. Further insert or finish presses are ignored.
- Press finish when `count`=3. Expect no strobe. Press clear mid-round. Expect one `clear` strobe and `count`=`num`=`done`=0.
- Press clear and insert so their events land on the same edge. Expect `clear` only and `count`=0. Assert `reset` mid-debounce. Expect all outputs 0 and no strobe from the interrupted press.
